// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with 2-entry skid buffer, registered in_ready and flush; PIPE_STAGE_PERF_EN adds perf counters
module pipe_stage_skid #(
    parameter int                DATA_W             = 128,
    parameter int                CTRL_W             = 16,
    parameter logic [CTRL_W-1:0] CTRL_RST           = '0,
    parameter bit                ZERO_DATA_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_bubble_cnt,
    output logic [15:0]       perf_flush_cnt
`endif
);
    logic              main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic              accept, main_free;

    assign in_ready  = ~skid_v_q;
    assign out_valid = main_v_q;
    assign out_ctrl  = main_v_q ? main_ctrl_q : CTRL_RST;
    assign out_data  = (ZERO_DATA_ON_FLUSH && !main_v_q) ? '0 : main_data_q;
    assign accept    = in_valid & ~skid_v_q;
    assign main_free = ~main_v_q | out_ready;

    // next entry state: skid drains into main first, so ordering stays FIFO; flush kills both entries
    always_comb begin
        main_v_d    = main_v_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (main_free) begin
            if (skid_v_q) begin
                main_v_d    = 1'b1;
                main_data_d = skid_data_q;
                main_ctrl_d = skid_ctrl_q;
                skid_v_d    = 1'b0;
            end else begin
                main_v_d = accept;
                if (accept) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end
            end
        end else if (accept) begin
            skid_v_d    = 1'b1;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
        end
    end

    // entry registers; reset drops everything at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v_q    <= 1'b0;
            main_data_q <= '0;
            main_ctrl_q <= CTRL_RST;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
            skid_ctrl_q <= CTRL_RST;
        end else begin
            main_v_q    <= main_v_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    assign perf_stall_cnt  = stall_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
    assign perf_flush_cnt  = flush_cnt_q;

    // wrapping event counters; flush does not clear them
    always_comb begin
        stall_cnt_d  = stall_cnt_q + 32'(main_v_q & ~out_ready);
        bubble_cnt_d = bubble_cnt_q + 32'(~main_v_q & out_ready);
        flush_cnt_d  = flush_cnt_q + 16'(flush);
    end

    // counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: scoreboard bench for pipe_stage_skid (two configurations side by side)
module tb_pipe_stage_skid;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_data = '0;
    logic [15:0]  in_ctrl = '0;
    logic         in_ready, out_valid, in_ready2, out_valid2;
    logic [127:0] out_data, out_data2;
    logic [15:0]  out_ctrl, out_ctrl2;
    logic [143:0] sb[$];
    int           n_tests = 0;
    int           n_fail = 0;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]  stall_cnt, bubble_cnt, stall_cnt2, bubble_cnt2;
    logic [15:0]  flush_cnt, flush_cnt2;
`endif

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(128), .CTRL_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl)
`ifdef PIPE_STAGE_PERF_EN
        , .perf_stall_cnt(stall_cnt), .perf_bubble_cnt(bubble_cnt), .perf_flush_cnt(flush_cnt)
`endif
    );

    pipe_stage_skid #(.DATA_W(128), .CTRL_W(16), .CTRL_RST(16'h0003), .ZERO_DATA_ON_FLUSH(1'b0)) dut2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_ctrl(out_ctrl2)
`ifdef PIPE_STAGE_PERF_EN
        , .perf_stall_cnt(stall_cnt2), .perf_bubble_cnt(bubble_cnt2), .perf_flush_cnt(flush_cnt2)
`endif
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // one clock cycle of stimulus; the expected output is queued when the handshake is accepted
    task automatic step(input logic v, input logic [127:0] d, input logic [15:0] c, input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        if (fl) sb.delete();
        else if (v && in_ready) sb.push_back({d, c});
        @(posedge clk);
        #1;
    endtask

    // monitor: pop on every transfer, and check bubble outputs of both configurations
    always @(negedge clk) begin
        logic [143:0] e;
        if (!rst) begin
            if (out_valid) begin
                if (out_ready && !flush) begin
                    if (sb.size() == 0) chk("sb_underflow", 128'd1, 128'd0);
                    else begin
                        e = sb.pop_front();
                        chk("out_data", out_data, e[143:16]);
                        chk("out_ctrl", out_ctrl, {112'd0, e[15:0]});
                        chk("out_valid2", {127'd0, out_valid2}, 128'd1);
                        chk("out_data2", out_data2, e[143:16]);
                        chk("out_ctrl2", out_ctrl2, {112'd0, e[15:0]});
                    end
                end
            end else begin
                chk("bubble_ctrl", out_ctrl, 128'd0);
                chk("bubble_data", out_data, 128'd0);
                chk("bubble_valid2", {127'd0, out_valid2}, 128'd0);
                chk("bubble_ctrl2", out_ctrl2, 128'h3);
            end
        end
    end

    initial begin
        #1;
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_out_ctrl", out_ctrl, 128'd0);
        chk("rst_out_ctrl2", out_ctrl2, 128'h3);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // streaming
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 128'(i), 16'(i), 1'b1, 1'b0);
            chk("stream_in_ready", {127'd0, in_ready}, 128'd1);
            chk("stream_out_valid", {127'd0, out_valid}, 128'd1);
            chk("stream_out_data", out_data, 128'(i));
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("stream_drained", {127'd0, out_valid}, 128'd0);
        // stall into skid
        step(1'b1, 128'hA, 16'h00A0, 1'b0, 1'b0);
        chk("skid_a_ready", {127'd0, in_ready}, 128'd1);
        chk("skid_a_data", out_data, 128'hA);
        step(1'b1, 128'hB, 16'h00B0, 1'b0, 1'b0);
        chk("skid_full_ready", {127'd0, in_ready}, 128'd0);
        chk("skid_hold_a", out_data, 128'hA);
        step(1'b1, 128'hEE, 16'h00EE, 1'b0, 1'b0);
        chk("stall_hold_data", out_data, 128'hA);
        chk("stall_hold_ctrl", out_ctrl, 128'hA0);
        chk("stall_ready", {127'd0, in_ready}, 128'd0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("drain_b_data", out_data, 128'hB);
        chk("drain_ready", {127'd0, in_ready}, 128'd1);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("drain_empty", {127'd0, out_valid}, 128'd0);
        // flush with main and skid full
        step(1'b1, 128'hA, 16'h00FF, 1'b0, 1'b0);
        step(1'b1, 128'hB, 16'h00BB, 1'b0, 1'b0);
        step(1'b1, 128'hC, 16'h00CC, 1'b0, 1'b1);
        chk("flush_valid", {127'd0, out_valid}, 128'd0);
        chk("flush_ctrl", out_ctrl, 128'd0);
        chk("flush_data", out_data, 128'd0);
        chk("flush_ready", {127'd0, in_ready}, 128'd1);
        chk("flush_ctrl2", out_ctrl2, 128'h3);
        chk("flush_valid2", {127'd0, out_valid2}, 128'd0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("flush_no_c", {127'd0, out_valid}, 128'd0);
        step(1'b1, 128'hD, 16'h1234, 1'b1, 1'b0);
        chk("post_flush_valid2", {127'd0, out_valid2}, 128'd1);
        chk("post_flush_data2", out_data2, 128'hD);
        chk("post_flush_ctrl2", out_ctrl2, 128'h1234);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        // asynchronous reset while stalled
        step(1'b1, 128'hA, 16'h00A0, 1'b0, 1'b0);
        chk("pre_rst_valid", {127'd0, out_valid}, 128'd1);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("arst_valid", {127'd0, out_valid}, 128'd0);
        chk("arst_ready", {127'd0, in_ready}, 128'd1);
        chk("arst_data", out_data, 128'd0);
        chk("arst_ctrl", out_ctrl, 128'd0);
        @(posedge clk);
        #1;
        chk("arst_hold_valid", {127'd0, out_valid}, 128'd0);
        chk("arst_hold_ctrl2", out_ctrl2, 128'h3);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_valid", {127'd0, out_valid}, 128'd0);
`ifdef PIPE_STAGE_PERF_EN
        step(1'b1, 128'h55, 16'h0055, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("perf_stall", {96'd0, stall_cnt}, 128'd3);
        chk("perf_bubble", {96'd0, bubble_cnt}, 128'd2);
        chk("perf_flush", {112'd0, flush_cnt}, 128'd1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("perf_stall2", {96'd0, stall_cnt}, 128'd3);
        chk("perf_flush2", {112'd0, flush_cnt}, 128'd2);
`endif
        step(1'b0, '0, '0, 1'b1, 1'b0);
        if (sb.size() != 0) chk("sb_leftover", 128'(sb.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
